alu_muldiv: RTL

Parametrised iterative multiply/divide unit with HI/LO result registers, sitting in the EX stage beside the combinational ALU. It executes MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO as multi-cycle operations and raises `busy` so the hazard unit can stall any consumer of HI/LO. Results are committed to HI/LO atomically on completion; an in-flight operation can be cancelled by a pipeline flush.

---
 rtl/alu_muldiv.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// ============================================================================
// Module      : alu_muldiv
// Description : Iterative radix-2 multiply/divide unit with HI/LO result
//               registers. Executes MULT, MULTU, DIV, DIVU over WIDTH RUN
//               cycles plus one FINISH cycle. MTHI and MTLO write HI or LO
//               directly in a single cycle.
// Ports       : clk         - clock, rising edge
//               rst_n       - asynchronous active-low reset
//               start       - request; accepted only while not busy
//               op[2:0]     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                             100 MTHI, 101 MTLO (110/111 ignored)
//               a, b        - rs / rt operands
//               cancel      - abort of the in-flight operation
//               busy        - operation in flight
//               done        - one-cycle pulse after HI/LO were written
//               div_by_zero - qualifies done for a divide with b = 0
//               hi, lo      - HI / LO registers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_div;
    logic               r_neg_q;    // product / quotient needs negation
    logic               r_neg_r;    // remainder takes the sign of a
    logic               r_bzero;
    logic [WIDTH-1:0]   r_a_raw;    // unmodified a, returned in HI on divide by zero
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor (magnitude)
    logic [WIDTH-1:0]   r_upper;    // accumulator high half / partial remainder
    logic [WIDTH-1:0]   r_lower;    // multiplier shifting out / quotient shifting in

    logic               w_idle;
    logic               w_op_valid;
    logic               w_accept;
    logic               w_accept_md;
    logic               w_accept_mt;
    logic               w_signed_op;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic               w_last;
    logic               w_commit;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_idle      = (r_state == S_IDLE);
    assign w_op_valid  = ~(op[2] & op[1]);
    assign w_accept    = start & w_idle & ~cancel & w_op_valid;
    assign w_accept_md = w_accept & ~op[2];
    assign w_accept_mt = w_accept &  op[2];
    assign w_signed_op = ~op[0];

    // The iteration runs on magnitudes; signs are restored in FINISH.
    assign w_abs_a = (w_signed_op & a[WIDTH-1]) ? -a : a;
    assign w_abs_b = (w_signed_op & b[WIDTH-1]) ? -b : b;

    // ------------------------------------------------------------------
    // Datapath step logic
    // ------------------------------------------------------------------
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set; the carry bit is shifted back into the accumulator.
    assign w_sum = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // Restoring divide: partial remainder is always below the divisor, so
    // the shifted value fits WIDTH+1 bits and the difference fits WIDTH bits.
    assign w_shift  = {r_upper, r_lower[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_opnd});
    assign w_diff   = w_shift - {1'b0, r_opnd};
    assign w_unused = w_diff[WIDTH];

    assign w_last   = (r_cnt == c_CNT_LAST);
    // A cancel landing on the completion edge wins over the commit.
    assign w_commit = (r_state == S_FINISH) & ~cancel;

    // Sign fixup
    assign w_prod     = {r_upper, r_lower};
    assign w_prod_fix = r_neg_q ? -w_prod  : w_prod;
    assign w_quot_fix = r_neg_q ? -r_lower : r_lower;
    assign w_rem_fix  = r_neg_r ? -r_upper : r_upper;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_md) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_a_raw  <= '0;
            r_opnd   <= '0;
            r_upper  <= '0;
            r_lower  <= '0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;

            if (w_accept_mt) begin
                if (op[0]) begin
                    r_lo <= a;
                end else begin
                    r_hi <= a;
                end
                r_done <= 1'b1;
            end

            if (w_accept_md) begin
                r_is_div <= op[1];
                r_neg_q  <= w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_r  <= w_signed_op & a[WIDTH-1];
                r_bzero  <= (b == '0);
                r_a_raw  <= a;
                r_upper  <= '0;
                r_cnt    <= '0;
                if (op[1]) begin
                    r_opnd  <= w_abs_b;     // divisor
                    r_lower <= w_abs_a;     // dividend
                end else begin
                    r_opnd  <= w_abs_a;     // multiplicand
                    r_lower <= w_abs_b;     // multiplier
                end
            end

            if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_is_div) begin
                    r_upper <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_lower <= {r_lower[WIDTH-2:0], w_ge};
                end else begin
                    {r_upper, r_lower} <= {w_sum, r_lower[WIDTH-1:1]};
                end
            end

            if (w_commit) begin
                r_done <= 1'b1;
                if (r_is_div) begin
                    if (r_bzero) begin
                        r_hi  <= r_a_raw;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end
                end else begin
                    {r_hi, r_lo} <= w_prod_fix;
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

`default_nettype wire
